// File: rtl/conv_stream_tx.sv
// conv_stream_tx
//   Transmit side of the convolution-engine input stream. Two upstream
//   AXI-stream sources (parameters/weights and features) are merged into one
//   tagged stream for the 3x3 convolution block. Each phase starts with a
//   Control command that also samples the phase's beat count. The final beat
//   of the phase carries M_Last. Done pulses for one cycle after that beat
//   has left the output register.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   Control              4'b0001 = parameter phase, 4'b0010 = feature phase
//   Para_Len, Feat_Len   beat counts, sampled with the start command
//   P_Data/P_Valid/P_Ready   parameter source (route tag 2'b00)
//   F_Data/F_Valid/F_Ready   feature source   (route tag 2'b01)
//   M_Data/M_Dest/M_Last/M_Valid/M_Ready   merged output stream
//   Busy                 high whenever a phase is in progress
//   Done                 one-cycle pulse at the end of a phase
module conv_stream_tx #(
  parameter int DATA_WIDTH = 128,
  parameter int WIDTH_LEN  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            Control,
  input  logic [WIDTH_LEN-1:0]  Para_Len,
  input  logic [WIDTH_LEN-1:0]  Feat_Len,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  P_Valid,
  output logic                  P_Ready,
  input  logic [DATA_WIDTH-1:0] F_Data,
  input  logic                  F_Valid,
  output logic                  F_Ready,
  output logic [DATA_WIDTH-1:0] M_Data,
  output logic [1:0]            M_Dest,
  output logic                  M_Last,
  output logic                  M_Valid,
  input  logic                  M_Ready,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [1:0] {IDLE, PARA, FEAT, DRAIN} state_t;

  localparam logic [WIDTH_LEN-1:0] LEN_ZERO = '0;
  localparam logic [WIDTH_LEN-1:0] LEN_ONE  = WIDTH_LEN'(1);

  state_t                state_q, state_d;
  logic [WIDTH_LEN-1:0]  cnt_q, cnt_d;
  logic [1:0]            dest_q, dest_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [1:0]            m_dest_q, m_dest_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;
  logic                  done_q, done_d;

  logic out_free;
  logic p_accept;
  logic f_accept;
  logic beat_accept;

  // The single output register can take a new beat when it is empty or its
  // current beat is leaving this cycle. Ready never looks at the source's
  // own valid, so there is no valid->ready combinational loop upstream.
  assign out_free    = !m_valid_q || M_Ready;
  assign P_Ready     = (state_q == PARA) && (cnt_q != LEN_ZERO) && out_free;
  assign F_Ready     = (state_q == FEAT) && (cnt_q != LEN_ZERO) && out_free;
  assign p_accept    = P_Valid && P_Ready;
  assign f_accept    = F_Valid && F_Ready;
  assign beat_accept = p_accept || f_accept;

  assign M_Data  = m_data_q;
  assign M_Dest  = m_dest_q;
  assign M_Last  = m_last_q;
  assign M_Valid = m_valid_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    m_data_d  = m_data_q;
    m_dest_d  = m_dest_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    done_d    = 1'b0;

    // Output stage: an accepted beat always wins over draining, which gives
    // full throughput when the consumer keeps M_Ready high.
    if (beat_accept) begin
      m_data_d  = p_accept ? P_Data : F_Data;
      m_dest_d  = dest_q;
      m_last_d  = (cnt_q == LEN_ONE);
      m_valid_d = 1'b1;
      cnt_d     = cnt_q - LEN_ONE;
    end else if (m_valid_q && M_Ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (Control == 4'b0001) begin
          dest_d = 2'b00;
          cnt_d  = Para_Len;
          if (Para_Len == LEN_ZERO) done_d = 1'b1;
          else                      state_d = PARA;
        end else if (Control == 4'b0010) begin
          dest_d = 2'b01;
          cnt_d  = Feat_Len;
          if (Feat_Len == LEN_ZERO) done_d = 1'b1;
          else                      state_d = FEAT;
        end
      end
      PARA, FEAT: begin
        if (beat_accept && (cnt_q == LEN_ONE)) state_d = DRAIN;
      end
      DRAIN: begin
        // The phase ends only once the marked last beat is taken downstream.
        if (m_valid_q && M_Ready && m_last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dest_q    <= 2'b00;
      m_data_q  <= '0;
      m_dest_q  <= 2'b00;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      m_data_q  <= m_data_d;
      m_dest_q  <= m_dest_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_stream_tx.sv
// tb_conv_stream_tx
//   Randomized self-checking bench for conv_stream_tx. A reference model
//   tracks each phase as a list of source words plus two indices (words taken
//   from the source, words delivered downstream) and derives every expected
//   output from those.
module tb_conv_stream_tx;

  localparam int DW = 128;
  localparam int WL = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    Control;
  logic [WL-1:0] Para_Len;
  logic [WL-1:0] Feat_Len;
  logic [DW-1:0] P_Data;
  logic          P_Valid;
  logic          P_Ready;
  logic [DW-1:0] F_Data;
  logic          F_Valid;
  logic          F_Ready;
  logic [DW-1:0] M_Data;
  logic [1:0]    M_Dest;
  logic          M_Last;
  logic          M_Valid;
  logic          M_Ready;
  logic          Busy;
  logic          Done;

  int total = 0;
  int bad   = 0;

  conv_stream_tx #(.DATA_WIDTH(DW), .WIDTH_LEN(WL)) dut (
    .clk(clk), .rst(rst), .Control(Control),
    .Para_Len(Para_Len), .Feat_Len(Feat_Len),
    .P_Data(P_Data), .P_Valid(P_Valid), .P_Ready(P_Ready),
    .F_Data(F_Data), .F_Valid(F_Valid), .F_Ready(F_Ready),
    .M_Data(M_Data), .M_Dest(M_Dest), .M_Last(M_Last),
    .M_Valid(M_Valid), .M_Ready(M_Ready),
    .Busy(Busy), .Done(Done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] randWord();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks that the block sits quietly in IDLE with nothing in flight.
  task automatic checkIdle(input string tag, input logic expDone);
    checkOutput({tag, "_done"}, Done, expDone);
    checkOutput({tag, "_busy"}, Busy, 1'b0);
    checkOutput({tag, "_mvalid"}, M_Valid, 1'b0);
    checkOutput({tag, "_pready"}, P_Ready, 1'b0);
    checkOutput({tag, "_fready"}, F_Ready, 1'b0);
  endtask

  // Runs one complete phase. Inputs change 1 time unit after each rising
  // edge; outputs are sampled on the falling edge.
  task automatic applyStimulus(input bit isFeat, input int len,
                               input int validPct, input int readyPct,
                               input bit cmdNoise);
    logic [DW-1:0] words[$];
    int   srcIdx   = 0;
    int   outIdx   = 0;
    int   cyc      = 0;
    bit   finished = 0;
    bit   srcValid;
    bit   expValid;
    bit   expReady;
    bit   rdy;
    logic [DW-1:0] srcWord;

    for (int i = 0; i < len; i++) words.push_back(randWord());

    @(posedge clk); #1;
    Control  = isFeat ? 4'b0010 : 4'b0001;
    Para_Len = isFeat ? WL'($urandom) : WL'(len);
    Feat_Len = isFeat ? WL'(len) : WL'($urandom);
    P_Valid  = 1'b0;
    F_Valid  = 1'b0;
    M_Ready  = 1'b0;
    @(posedge clk); #1;
    Control = 4'b0000;

    if (len == 0) begin
      @(negedge clk);
      checkIdle("zero_first", 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      checkIdle("zero_second", 1'b0);
      return;
    end

    while (!finished && cyc < 3000) begin
      srcValid = (srcIdx < len) && ($urandom_range(99) < validPct);
      srcWord  = (srcIdx < len) ? words[srcIdx] : randWord();
      rdy      = ($urandom_range(99) < readyPct);
      if (isFeat) begin
        F_Valid = srcValid;           F_Data = srcWord;
        P_Valid = $urandom_range(1);  P_Data = randWord();
      end else begin
        P_Valid = srcValid;           P_Data = srcWord;
        F_Valid = $urandom_range(1);  F_Data = randWord();
      end
      M_Ready = rdy;
      Control = cmdNoise ? 4'($urandom_range(15)) : 4'b0000;

      @(negedge clk);
      expValid = (srcIdx > outIdx);
      expReady = (srcIdx < len) && (!expValid || rdy);
      checkOutput("busy", Busy, 1'b1);
      checkOutput("done_early", Done, 1'b0);
      checkOutput("m_valid", M_Valid, expValid);
      checkOutput("src_ready", isFeat ? F_Ready : P_Ready, expReady);
      checkOutput("other_ready", isFeat ? P_Ready : F_Ready, 1'b0);
      if (expValid) begin
        checkOutput("m_data", M_Data, words[outIdx]);
        checkOutput("m_dest", M_Dest, isFeat ? 2'b01 : 2'b00);
        checkOutput("m_last", M_Last, (outIdx == len - 1));
      end

      @(posedge clk); #1;
      if (srcValid && expReady) srcIdx++;
      if (expValid && rdy) begin
        if (outIdx == len - 1) finished = 1;
        outIdx++;
      end
      cyc++;
    end

    checkOutput("phase_beats", outIdx, len);
    checkOutput("src_taken", srcIdx, len);
    if (validPct == 100 && readyPct == 100)
      checkOutput("throughput", cyc, len + 1);

    Control = 4'b0000;
    P_Valid = 1'b0;
    F_Valid = 1'b0;
    M_Ready = $urandom_range(1);
    @(negedge clk);
    checkIdle("end_first", 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkIdle("end_second", 1'b0);
  endtask

  // Starts an 8-beat parameter phase and hits reset while beat 2 is held
  // in the output register.
  task automatic resetMidPhase();
    int seen = 0;
    int cyc  = 0;
    @(posedge clk); #1;
    Control  = 4'b0001;
    Para_Len = WL'(8);
    P_Valid  = 1'b0;
    M_Ready  = 1'b1;
    @(posedge clk); #1;
    Control = 4'b0000;
    P_Valid = 1'b1;
    while (seen < 2 && cyc < 20) begin
      P_Data = randWord();
      @(negedge clk);
      if (M_Valid) seen++;
      if (seen < 2) begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    checkOutput("rst_reach_beat2", seen, 2);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mvalid", M_Valid, 1'b0);
    checkOutput("rst_busy", Busy, 1'b0);
    checkOutput("rst_pready", P_Ready, 1'b0);
    checkOutput("rst_fready", F_Ready, 1'b0);
    checkOutput("rst_done", Done, 1'b0);
    checkOutput("rst_mdata", M_Data, '0);
    @(posedge clk); #1;
    rst     = 1'b0;
    P_Valid = 1'b0;
    @(negedge clk);
    checkIdle("post_rst", 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkIdle("post_rst2", 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    Control  = 4'b0000;
    Para_Len = '0;
    Feat_Len = '0;
    P_Data   = '0;
    P_Valid  = 1'b0;
    F_Data   = '0;
    F_Valid  = 1'b0;
    M_Ready  = 1'b0;
    #2;
    checkIdle("reset", 1'b0);
    checkOutput("reset_mdata", M_Data, '0);
    checkOutput("reset_mdest", M_Dest, 2'b00);
    checkOutput("reset_mlast", M_Last, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] parameter phase, len 4, full rate");
    applyStimulus(1'b0, 4, 100, 100, 1'b0);
    $display("[TB] feature phase, len 3, back-pressure");
    applyStimulus(1'b1, 3, 100, 50, 1'b0);
    $display("[TB] zero-length parameter phase");
    applyStimulus(1'b0, 0, 100, 100, 1'b0);
    $display("[TB] zero-length feature phase");
    applyStimulus(1'b1, 0, 100, 100, 1'b0);
    $display("[TB] feature phase, len 5, stray commands");
    applyStimulus(1'b1, 5, 100, 100, 1'b1);
    $display("[TB] parameter phase, len 6, stalling source");
    applyStimulus(1'b0, 6, 35, 100, 1'b0);
    $display("[TB] single-beat phases");
    applyStimulus(1'b0, 1, 100, 100, 1'b0);
    applyStimulus(1'b1, 1, 60, 60, 1'b1);
    $display("[TB] reset mid-phase");
    resetMidPhase();
    applyStimulus(1'b1, 2, 100, 100, 1'b0);
    $display("[TB] random phases");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'($urandom_range(1)), $urandom_range(12),
                    $urandom_range(30, 100), $urandom_range(30, 100),
                    1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
